// File: rtl/ldpc_ber_pkg.sv
// Shared constants for the multi-channel LDPC BER register map.
// latency: n/a; backpressure: n/a.
package ldpc_ber_pkg;

  localparam logic [31:0] CORE_VERSION = 32'h0002_0061;
  localparam logic [31:0] CORE_MAGIC   = 32'h4350_444C;

  localparam logic [2:0] GLB_VERSION = 3'd0;
  localparam logic [2:0] GLB_SEED_ID = 3'd1;
  localparam logic [2:0] GLB_SCRATCH = 3'd2;
  localparam logic [2:0] GLB_MAGIC   = 3'd3;
  localparam logic [2:0] GLB_NUM_CH  = 3'd4;
  localparam logic [2:0] GLB_BCAST   = 3'd5;

  localparam int CH_BASE   = 'h100;
  localparam int CH_STRIDE = 'h20;
  localparam int CH_OFS_W  = $clog2(CH_STRIDE);

  localparam logic [4:0] CH_CTRL     = 5'h00;
  localparam logic [4:0] CH_AWGN     = 5'h01;
  localparam logic [4:0] CH_BEATS    = 5'h02;
  localparam logic [4:0] CH_WORD     = 5'h03;
  localparam logic [4:0] CH_MASK0    = 5'h04;
  localparam logic [4:0] CH_BLK_LO   = 5'h10;
  localparam logic [4:0] CH_BLK_HI   = 5'h11;
  localparam logic [4:0] CH_ERR_LO   = 5'h12;
  localparam logic [4:0] CH_ERR_HI   = 5'h13;
  localparam logic [4:0] CH_INFLIGHT = 5'h14;

  localparam int RESET_PULSE_MAX = 255;

endpackage

// File: rtl/ldpc_ber_multi_regmap_if.sv
// Up-bus register port: single-cycle read/write strobes, one-cycle acks.
// latency: 1 cycle to ack; backpressure: none, every strobe is acknowledged.
interface ldpc_ber_multi_regmap_if #(
  parameter int ADDRESS_WIDTH = 10
);
  logic                     up_rreq;
  logic [ADDRESS_WIDTH-1:0] up_raddr;
  logic                     up_rack;
  logic [31:0]              up_rdata;
  logic                     up_wreq;
  logic [ADDRESS_WIDTH-1:0] up_waddr;
  logic [31:0]              up_wdata;
  logic                     up_wack;

  modport master (
    output up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
    input  up_rack, up_rdata, up_wack
  );

  modport slave (
    input  up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
    output up_rack, up_rdata, up_wack
  );
endinterface

// File: rtl/ldpc_ber_reset_pulse.sv
// Stretched active-low soft reset; a trigger (re)loads the width counter.
// latency: resetn_out falls 1 cycle after trigger; backpressure: none.
module ldpc_ber_reset_pulse #(
  parameter int PULSE_CYCLES = 4
) (
  input  logic up_clk,
  input  logic up_resetn,
  input  logic trigger,
  output logic resetn_out,
  output logic busy
);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = 8'(PULSE_CYCLES);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Loading on reset keeps the channel held for a full pulse after release.
  always_ff @(posedge up_clk or negedge up_resetn) begin
    if (!up_resetn) begin
      cnt_q <= 8'(PULSE_CYCLES);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign resetn_out = (cnt_q == 8'd0);
  assign busy       = (cnt_q != 8'd0);

endmodule

// File: rtl/ldpc_ber_multi_regmap.sv
// Multi-channel LDPC BER tester register map with per-channel windows and snapshots.
// latency: write/read ack 1 cycle after strobe; backpressure: none.
module ldpc_ber_multi_regmap
  import ldpc_ber_pkg::*;
#(
  parameter logic [31:0] SEED_ID            = 32'h0,
  parameter int          ADDRESS_WIDTH      = 10,
  parameter int          NUM_CH             = 4,
  parameter int          RESET_PULSE_CYCLES = 4
) (
  input  logic                    up_clk,
  input  logic                    up_resetn,
  ldpc_ber_multi_regmap_if.slave  up,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_sw_resetn,
  output logic [16*NUM_CH-1:0]    ch_factor,
  output logic [8*NUM_CH-1:0]     ch_offset,
  output logic [16*NUM_CH-1:0]    ch_din_beats,
  output logic [32*NUM_CH-1:0]    ch_ctrl_word,
  output logic [128*NUM_CH-1:0]   ch_last_mask,
  input  logic [64*NUM_CH-1:0]    ch_finished_blocks,
  input  logic [64*NUM_CH-1:0]    ch_bit_errors,
  input  logic [32*NUM_CH-1:0]    ch_in_flight
);

  localparam int AW        = ADDRESS_WIDTH;
  localparam int PULSE_LEN = (RESET_PULSE_CYCLES > RESET_PULSE_MAX) ? RESET_PULSE_MAX
                                                                    : RESET_PULSE_CYCLES;

  logic [AW-1:0] waddr, raddr;
  logic [31:0]   wdata;
  logic [2:0]    w_idx, r_idx;
  logic          w_glb, r_glb, w_ch, r_ch, bcast_wr;

  assign waddr = up.up_waddr;
  assign raddr = up.up_raddr;
  assign wdata = up.up_wdata;
  assign w_idx = waddr[CH_OFS_W+2:CH_OFS_W];
  assign r_idx = raddr[CH_OFS_W+2:CH_OFS_W];

  assign w_glb = (waddr[AW-1:3] == '0);
  assign r_glb = (raddr[AW-1:3] == '0);
  assign w_ch  = (waddr[AW-1:CH_OFS_W+3] == (AW-CH_OFS_W-3)'(CH_BASE >> (CH_OFS_W+3)))
              && ({1'b0, w_idx} < 4'(NUM_CH));
  assign r_ch  = (raddr[AW-1:CH_OFS_W+3] == (AW-CH_OFS_W-3)'(CH_BASE >> (CH_OFS_W+3)))
              && ({1'b0, r_idx} < 4'(NUM_CH));
  assign bcast_wr = up.up_wreq && w_glb && (waddr[2:0] == GLB_BCAST);

  logic [31:0] ch_rd [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          wsel, rsnap, trig, busy;
    logic          en_d, en_q;
    logic [15:0]   factor_d, factor_q, beats_d, beats_q;
    logic [7:0]    offset_d, offset_q;
    logic [31:0]   ctrl_d, ctrl_q, blk_hi_d, blk_hi_q, inf_d, inf_q, rd_val;
    logic [127:0]  mask_d, mask_q;
    logic [63:0]   err_d, err_q;

    assign wsel  = up.up_wreq && w_ch && (w_idx == 3'(c));
    assign rsnap = up.up_rreq && r_ch && (r_idx == 3'(c))
                && (raddr[CH_OFS_W-1:0] == CH_BLK_LO);

    always_comb begin
      en_d     = en_q;
      factor_d = factor_q;
      offset_d = offset_q;
      beats_d  = beats_q;
      ctrl_d   = ctrl_q;
      mask_d   = mask_q;
      blk_hi_d = blk_hi_q;
      err_d    = err_q;
      inf_d    = inf_q;
      trig     = 1'b0;
      if (wsel) begin
        case (waddr[CH_OFS_W-1:0])
          CH_CTRL:  begin en_d = wdata[0]; trig = wdata[1]; end
          CH_AWGN:  begin factor_d = wdata[15:0]; offset_d = wdata[23:16]; end
          CH_BEATS: beats_d = wdata[15:0];
          CH_WORD:  ctrl_d = wdata;
          CH_MASK0:         mask_d[31:0]   = wdata;
          CH_MASK0 + 5'd1:  mask_d[63:32]  = wdata;
          CH_MASK0 + 5'd2:  mask_d[95:64]  = wdata;
          CH_MASK0 + 5'd3:  mask_d[127:96] = wdata;
          default: ;
        endcase
      end
      // Clear beats set when both are requested.
      if (bcast_wr && wdata[c]) begin
        if (wdata[9]) begin
          en_d = 1'b0;
        end else if (wdata[8]) begin
          en_d = 1'b1;
        end
        if (wdata[10]) trig = 1'b1;
      end
      if (rsnap) begin
        blk_hi_d = ch_finished_blocks[c*64+32 +: 32];
        err_d    = ch_bit_errors[c*64 +: 64];
        inf_d    = ch_in_flight[c*32 +: 32];
      end
    end

    always_ff @(posedge up_clk or negedge up_resetn) begin
      if (!up_resetn) begin
        en_q     <= 1'b0;
        factor_q <= '0;
        offset_q <= '0;
        beats_q  <= '0;
        ctrl_q   <= '0;
        mask_q   <= '0;
        blk_hi_q <= '0;
        err_q    <= '0;
        inf_q    <= '0;
      end else begin
        en_q     <= en_d;
        factor_q <= factor_d;
        offset_q <= offset_d;
        beats_q  <= beats_d;
        ctrl_q   <= ctrl_d;
        mask_q   <= mask_d;
        blk_hi_q <= blk_hi_d;
        err_q    <= err_d;
        inf_q    <= inf_d;
      end
    end

    ldpc_ber_reset_pulse #(.PULSE_CYCLES(PULSE_LEN)) u_pulse (
      .up_clk     (up_clk),
      .up_resetn  (up_resetn),
      .trigger    (trig),
      .resetn_out (ch_sw_resetn[c]),
      .busy       (busy)
    );

    // The lo word is served live; the same read latches the rest into the shadow.
    always_comb begin
      rd_val = '0;
      case (raddr[CH_OFS_W-1:0])
        CH_CTRL:          rd_val = {30'd0, busy, en_q};
        CH_AWGN:          rd_val = {8'h0, offset_q, factor_q};
        CH_BEATS:         rd_val = {16'h0, beats_q};
        CH_WORD:          rd_val = ctrl_q;
        CH_MASK0:         rd_val = mask_q[31:0];
        CH_MASK0 + 5'd1:  rd_val = mask_q[63:32];
        CH_MASK0 + 5'd2:  rd_val = mask_q[95:64];
        CH_MASK0 + 5'd3:  rd_val = mask_q[127:96];
        CH_BLK_LO:        rd_val = ch_finished_blocks[c*64 +: 32];
        CH_BLK_HI:        rd_val = blk_hi_q;
        CH_ERR_LO:        rd_val = err_q[31:0];
        CH_ERR_HI:        rd_val = err_q[63:32];
        CH_INFLIGHT:      rd_val = inf_q;
        default: ;
      endcase
    end

    assign ch_rd[c]                   = rd_val;
    assign ch_en[c]                   = en_q;
    assign ch_factor[c*16 +: 16]      = factor_q;
    assign ch_offset[c*8 +: 8]        = offset_q;
    assign ch_din_beats[c*16 +: 16]   = beats_q;
    assign ch_ctrl_word[c*32 +: 32]   = ctrl_q;
    assign ch_last_mask[c*128 +: 128] = mask_q;
  end

  logic [31:0] scratch_d, scratch_q, rdata_d, rdata_q;
  logic        rack_d, rack_q, wack_d, wack_q;

  always_comb begin
    scratch_d = scratch_q;
    if (up.up_wreq && w_glb && (waddr[2:0] == GLB_SCRATCH)) scratch_d = wdata;
    rack_d  = up.up_rreq;
    wack_d  = up.up_wreq;
    rdata_d = rdata_q;
    if (up.up_rreq) begin
      rdata_d = '0;
      if (r_glb) begin
        case (raddr[2:0])
          GLB_VERSION: rdata_d = CORE_VERSION;
          GLB_SEED_ID: rdata_d = SEED_ID;
          GLB_SCRATCH: rdata_d = scratch_q;
          GLB_MAGIC:   rdata_d = CORE_MAGIC;
          GLB_NUM_CH:  rdata_d = 32'(NUM_CH);
          default: ;
        endcase
      end else if (r_ch) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_idx == 3'(c)) rdata_d = ch_rd[c];
        end
      end
    end
  end

  always_ff @(posedge up_clk or negedge up_resetn) begin
    if (!up_resetn) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      rack_q    <= 1'b0;
      wack_q    <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rack_q    <= rack_d;
      wack_q    <= wack_d;
    end
  end

  assign up.up_rdata = rdata_q;
  assign up.up_rack  = rack_q;
  assign up.up_wack  = wack_q;

endmodule

// File: tb/tb_ldpc_ber_multi_regmap.sv
// Directed plus randomized register traffic checked against a behavioural register model.
module tb_ldpc_ber_multi_regmap;

  localparam int          AW   = 10;
  localparam int          NCH  = 4;
  localparam int          P    = 4;
  localparam logic [31:0] SEED = 32'hC0DE_0042;

  logic up_clk = 1'b0;
  logic up_resetn = 1'b1;
  always #5 up_clk = ~up_clk;

  ldpc_ber_multi_regmap_if #(.ADDRESS_WIDTH(AW)) up_if ();

  logic [NCH-1:0]      ch_en, ch_sw_resetn;
  logic [16*NCH-1:0]   ch_factor, ch_din_beats;
  logic [8*NCH-1:0]    ch_offset;
  logic [32*NCH-1:0]   ch_ctrl_word, in_flight;
  logic [128*NCH-1:0]  ch_last_mask;
  logic [64*NCH-1:0]   blocks, errors;

  ldpc_ber_multi_regmap #(
    .SEED_ID(SEED), .ADDRESS_WIDTH(AW), .NUM_CH(NCH), .RESET_PULSE_CYCLES(P)
  ) dut (
    .up_clk(up_clk), .up_resetn(up_resetn), .up(up_if),
    .ch_en(ch_en), .ch_sw_resetn(ch_sw_resetn), .ch_factor(ch_factor),
    .ch_offset(ch_offset), .ch_din_beats(ch_din_beats), .ch_ctrl_word(ch_ctrl_word),
    .ch_last_mask(ch_last_mask), .ch_finished_blocks(blocks),
    .ch_bit_errors(errors), .ch_in_flight(in_flight)
  );

  int n_assert = 0, n_fail = 0, cyc = 0, lowcnt3 = 0;
  bit in_rst = 1'b1, mon_on = 1'b0;
  logic [31:0] last_rd;

  // Behavioural model: register contents plus the set of cycles each channel is held in reset.
  logic [31:0] m_scratch;
  bit          m_en     [NCH];
  logic [15:0] m_factor [NCH];
  logic [7:0]  m_offset [NCH];
  logic [15:0] m_beats  [NCH];
  logic [31:0] m_ctrl   [NCH];
  logic [31:0] m_mask   [NCH][4];
  logic [63:0] m_sh_blk [NCH];
  logic [63:0] m_sh_err [NCH];
  logic [31:0] m_sh_inf [NCH];
  bit          lowmap   [int];

  always @(posedge up_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_scratch = '0;
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 1'b0; m_factor[c] = '0; m_offset[c] = '0; m_beats[c] = '0; m_ctrl[c] = '0;
      for (int w = 0; w < 4; w++) m_mask[c][w] = '0;
      m_sh_blk[c] = '0; m_sh_err[c] = '0; m_sh_inf[c] = '0;
    end
    lowmap.delete();
  endfunction

  function automatic void mark(int c, int from);
    for (int i = 0; i < P; i++) lowmap[(from + i) * NCH + c] = 1'b1;
  endfunction

  function automatic bit m_busy(int c, int t);
    return lowmap.exists(t * NCH + c);
  endfunction

  function automatic logic [31:0] model_read(int a);
    logic [31:0] r = '0;
    int c, o;
    if (a < 8) begin
      case (a)
        0: r = 32'h0002_0061;
        1: r = SEED;
        2: r = m_scratch;
        3: r = 32'h4350_444C;
        4: r = NCH;
        default: r = '0;
      endcase
    end else if (a >= 256 && a < 256 + 32 * NCH) begin
      c = (a - 256) / 32;
      o = (a - 256) % 32;
      case (o)
        0: r = {30'd0, m_busy(c, cyc), m_en[c]};
        1: r = {8'h0, m_offset[c], m_factor[c]};
        2: r = {16'h0, m_beats[c]};
        3: r = m_ctrl[c];
        4, 5, 6, 7: r = m_mask[c][o - 4];
        16: begin
          m_sh_blk[c] = blocks[c*64 +: 64];
          m_sh_err[c] = errors[c*64 +: 64];
          m_sh_inf[c] = in_flight[c*32 +: 32];
          r = m_sh_blk[c][31:0];
        end
        17: r = m_sh_blk[c][63:32];
        18: r = m_sh_err[c][31:0];
        19: r = m_sh_err[c][63:32];
        20: r = m_sh_inf[c];
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic void model_write(int a, logic [31:0] d);
    int c, o;
    if (a == 2) m_scratch = d;
    else if (a == 5) begin
      for (c = 0; c < NCH; c++) begin
        if (d[c]) begin
          if (d[9]) m_en[c] = 1'b0;
          else if (d[8]) m_en[c] = 1'b1;
          if (d[10]) mark(c, cyc + 1);
        end
      end
    end else if (a >= 256 && a < 256 + 32 * NCH) begin
      c = (a - 256) / 32;
      o = (a - 256) % 32;
      case (o)
        0: begin m_en[c] = d[0]; if (d[1]) mark(c, cyc + 1); end
        1: begin m_factor[c] = d[15:0]; m_offset[c] = d[23:16]; end
        2: m_beats[c] = d[15:0];
        3: m_ctrl[c] = d;
        4, 5, 6, 7: m_mask[c][o - 4] = d;
        default: ;
      endcase
    end
  endfunction

  task automatic check_cfg();
    logic [511:0] e_en, e_fac, e_ofs, e_beats, e_ctrl, e_mask;
    e_en = '0; e_fac = '0; e_ofs = '0; e_beats = '0; e_ctrl = '0; e_mask = '0;
    for (int c = 0; c < NCH; c++) begin
      e_en[c] = m_en[c];
      e_fac[c*16 +: 16]   = m_factor[c];
      e_ofs[c*8 +: 8]     = m_offset[c];
      e_beats[c*16 +: 16] = m_beats[c];
      e_ctrl[c*32 +: 32]  = m_ctrl[c];
      for (int w = 0; w < 4; w++) e_mask[c*128 + w*32 +: 32] = m_mask[c][w];
    end
    chk("ch_en", ch_en, e_en);
    chk("ch_factor", ch_factor, e_fac);
    chk("ch_offset", ch_offset, e_ofs);
    chk("ch_din_beats", ch_din_beats, e_beats);
    chk("ch_ctrl_word", ch_ctrl_word, e_ctrl);
    chk("ch_last_mask", ch_last_mask, e_mask);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge up_clk);
    up_if.up_wreq = 1'b1; up_if.up_waddr = AW'(a); up_if.up_wdata = d;
    model_write(a, d);
    @(negedge up_clk);
    up_if.up_wreq = 1'b0;
    chk("wack", up_if.up_wack, 1);
    chk("rdata_hold", up_if.up_rdata, last_rd);
    check_cfg();
  endtask

  task automatic rd(input int a, output logic [31:0] got);
    logic [31:0] e;
    @(negedge up_clk);
    up_if.up_rreq = 1'b1; up_if.up_raddr = AW'(a);
    e = model_read(a);
    @(negedge up_clk);
    up_if.up_rreq = 1'b0;
    got = up_if.up_rdata;
    last_rd = e;
    chk($sformatf("rd_%03h", a), got, e);
    chk("rack", up_if.up_rack, 1);
    chk("wack_idle", up_if.up_wack, 0);
  endtask

  always @(posedge up_clk) begin
    #1;
    if (mon_on) begin
      for (int c = 0; c < NCH; c++)
        chk($sformatf("sw_resetn_%0d", c), ch_sw_resetn[c], (in_rst || m_busy(c, cyc)) ? 0 : 1);
      if (!in_rst && !ch_sw_resetn[3]) lowcnt3++;
    end
  end

  initial begin
    logic [31:0] g, e;
    int lowc;
    up_if.up_rreq = 1'b0; up_if.up_wreq = 1'b0;
    up_if.up_raddr = '0; up_if.up_waddr = '0; up_if.up_wdata = '0;
    for (int w = 0; w < 8 * NCH; w++) begin
      blocks[w*32 % (64*NCH) +: 32] = $urandom();
      errors[w*32 % (64*NCH) +: 32] = $urandom();
    end
    for (int w = 0; w < NCH; w++) in_flight[w*32 +: 32] = $urandom();
    model_reset();
    last_rd = '0;
    #1 up_resetn = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge up_clk);
    chk("rst_rack", up_if.up_rack, 0);
    chk("rst_wack", up_if.up_wack, 0);
    chk("rst_rdata", up_if.up_rdata, 0);
    chk("rst_sw_resetn", ch_sw_resetn, 0);
    check_cfg();

    up_resetn = 1'b1; in_rst = 1'b0;
    for (int c = 0; c < NCH; c++) mark(c, cyc);
    #1 lowc = !ch_sw_resetn[0];
    repeat (7) begin
      @(posedge up_clk); #2;
      if (!ch_sw_resetn[0]) lowc++;
    end
    chk("pulse_after_release", lowc, P);
    chk("all_released", ch_sw_resetn, {NCH{1'b1}});

    rd(12'h000, g); chk("version", g, 32'h0002_0061);
    rd(12'h001, g); chk("seed_id", g, SEED);
    rd(12'h003, g); chk("magic", g, 32'h4350_444C);
    rd(12'h004, g); chk("num_ch", g, NCH);

    wr(12'h122, 32'h1234_ABCD);
    chk("ch1_beats", ch_din_beats[31:16], 16'hABCD);
    chk("ch0_beats", ch_din_beats[15:0], 16'h0);
    chk("ch2_beats", ch_din_beats[47:32], 16'h0);
    rd(12'h122, g); chk("ch1_beats_rb", g, 32'h0000_ABCD);

    blocks[2*64 +: 64] = 64'h1_FFFF_FFFF;
    rd(12'h150, g); chk("blk_lo_capture", g, 32'hFFFF_FFFF);
    blocks[2*64 +: 64] = 64'h2_0000_0000;
    rd(12'h151, g); chk("blk_hi_shadow", g, 32'h0000_0001);

    lowcnt3 = 0;
    wr(12'h160, 32'h2);
    wr(12'h160, 32'h2);
    rd(12'h160, g); chk("ctrl_busy_bit", g[1], 1'b1);
    repeat (10) @(negedge up_clk);
    chk("retrigger_width", lowcnt3, 6);

    wr(12'h005, 32'h505);
    chk("bcast_en0", ch_en[0], 1'b1);
    chk("bcast_en2", ch_en[2], 1'b1);
    chk("bcast_rst0", ch_sw_resetn[0], 1'b0);
    chk("bcast_rst2", ch_sw_resetn[2], 1'b0);
    wr(12'h005, 32'h305);
    chk("bcast_clr", {ch_en[2], ch_en[0]}, 2'b00);

    wr(12'h180, 32'hFFFF_FFFF);
    rd(12'h180, g); chk("unmapped_ch4", g, 0);
    rd(12'h0F0, g); chk("unmapped_low", g, 0);
    rd(12'h005, g); chk("bcast_reads0", g, 0);
    rd(12'h11F, g); chk("unmapped_ofs", g, 0);

    @(negedge up_clk);
    up_if.up_wreq = 1'b1; up_if.up_waddr = AW'(2); up_if.up_wdata = 32'hDEAD_0002;
    up_if.up_rreq = 1'b1; up_if.up_raddr = AW'(2);
    e = model_read(2);
    model_write(2, 32'hDEAD_0002);
    @(negedge up_clk);
    up_if.up_wreq = 1'b0; up_if.up_rreq = 1'b0;
    last_rd = e;
    chk("rw_same_old", up_if.up_rdata, e);
    chk("rw_same_ack", {up_if.up_rack, up_if.up_wack}, 2'b11);
    rd(2, g); chk("scratch_new", g, 32'hDEAD_0002);

    for (int i = 0; i < 300; i++) begin
      int a, k;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      if (k == 0) a = $urandom_range(0, 7);
      else if (k == 1) a = $urandom_range(0, 1023);
      else a = 256 + 32 * $urandom_range(0, NCH) + $urandom_range(0, 7)
               + ($urandom_range(0, 1) ? 16 : 0);
      d = $urandom();
      if (k == 2) blocks[$urandom_range(0, 2*NCH-1)*32 +: 32] = $urandom();
      if (k == 3) errors[$urandom_range(0, 2*NCH-1)*32 +: 32] = $urandom();
      if (k == 4) in_flight[$urandom_range(0, NCH-1)*32 +: 32] = $urandom();
      if ($urandom_range(0, 1)) wr(a, d);
      else rd(a, g);
    end

    wr(12'h100, 32'h1);
    @(negedge up_clk);
    up_if.up_wreq = 1'b1; up_if.up_waddr = AW'(2); up_if.up_wdata = 32'h5555_AAAA;
    @(posedge up_clk); #2;
    chk("wack_before_rst", up_if.up_wack, 1);
    up_resetn = 1'b0; in_rst = 1'b1;
    model_reset();
    last_rd = '0;
    #1;
    chk("arst_wack", up_if.up_wack, 0);
    chk("arst_en", ch_en, 0);
    chk("arst_sw_resetn", ch_sw_resetn, 0);
    chk("arst_rdata", up_if.up_rdata, 0);
    up_if.up_wreq = 1'b0;
    repeat (2) @(negedge up_clk);
    up_resetn = 1'b1; in_rst = 1'b0;
    for (int c = 0; c < NCH; c++) mark(c, cyc);
    rd(2, g); chk("scratch_after_arst", g, 0);
    rd(12'h100, g);
    repeat (8) @(negedge up_clk);
    check_cfg();

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
